e_mdu: RTL and testbench

//  Multi-cycle multiply/divide unit owning the HI/LO registers; sits in the E stage beside the ALU.

---
 rtl/e_mdu.sv | 180 ++++++++++++++++++
 tb/tb_e_mdu.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
// e_mdu: multi-cycle multiply/divide unit owning the HI/LO registers (E stage).
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   Req       in   exception/interrupt flush; blocks starts and MTHI/MTLO writes this cycle
//   start     in   E-stage instruction is an MDU op (qualifies op)
//   op        in   0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO
//   rs, rt    in   operands (rs also carries MTHI/MTLO data)
//   busy      out  registered; high while a mult/div is in flight
//   busy_any  out  busy, or a mult/div being issued this cycle (combinational, for the stall)
//   hi, lo    out  HI/LO registers
//   mdu_out   out  MFHI/MFLO read data (combinational)
//
// A started mult/div holds busy for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES) and
// writes HI/LO on the edge that ends the busy window. The result is computed from operands
// latched at the start edge, so rs/rt may change freely while running.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic        busy_any,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdu_out
);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
  localparam logic [3:0] OpMfhi  = 4'd7;
  localparam logic [3:0] OpMflo  = 4'd8;

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  // Counter only ever holds N-1, so clog2(max N) bits is enough.
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES - 1);
  localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e         state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]    hi_q, hi_d;
  logic [31:0]    lo_q, lo_d;
  logic [31:0]    a_q, a_d;
  logic [31:0]    b_q, b_d;
  logic [3:0]     op_q, op_d;

  logic        is_muldiv;
  logic        is_mult;
  logic        accept;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] div_b;
  logic [31:0] udiv_q, udiv_r;
  logic [31:0] abs_a, abs_b;
  logic [31:0] sq_mag, sr_mag;
  logic [31:0] sdiv_q, sdiv_r;

  assign is_muldiv = (op >= OpMult) && (op <= OpDivu);
  assign is_mult   = (op == OpMult) || (op == OpMultu);
  assign accept    = start && !Req && (state_q == StIdle);

  assign busy     = (state_q == StRun);
  assign busy_any = busy || (start && is_muldiv && !Req);
  assign hi       = hi_q;
  assign lo       = lo_q;

  always_comb begin
    mdu_out = 32'd0;
    if (op == OpMfhi) begin
      mdu_out = hi_q;
    end else if (op == OpMflo) begin
      mdu_out = lo_q;
    end
  end

  // Datapath on latched operands.
  always_comb begin
    prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    // Divisor forced nonzero so the dividers never see x/0; the zero case is not written back.
    div_b  = (b_q == 32'd0) ? 32'd1 : b_q;
    udiv_q = a_q / div_b;
    udiv_r = a_q % div_b;
    // Signed divide via magnitudes: truncates toward zero, remainder follows dividend sign,
    // and 0x80000000 / -1 wraps to 0x80000000 with no special case.
    abs_a  = a_q[31] ? (32'd0 - a_q) : a_q;
    abs_b  = div_b[31] ? (32'd0 - div_b) : div_b;
    sq_mag = abs_a / abs_b;
    sr_mag = abs_a % abs_b;
    sdiv_q = (a_q[31] ^ div_b[31]) ? (32'd0 - sq_mag) : sq_mag;
    sdiv_r = a_q[31] ? (32'd0 - sr_mag) : sr_mag;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_muldiv) begin
            a_d     = rs;
            b_d     = rt;
            op_d    = op;
            cnt_d   = is_mult ? MultLoad : DivLoad;
            state_d = StRun;
          end else if (op == OpMthi) begin
            hi_d = rs;
          end else if (op == OpMtlo) begin
            lo_d = rs;
          end
        end
      end
      StRun: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
          case (op_q)
            OpMult:  {hi_d, lo_d} = prod_s;
            OpMultu: {hi_d, lo_d} = prod_u;
            OpDiv: begin
              if (b_q != 32'd0) begin
                lo_d = sdiv_q;
                hi_d = sdiv_r;
              end
            end
            OpDivu: begin
              if (b_q != 32'd0) begin
                lo_d = udiv_q;
                hi_d = udiv_r;
              end
            end
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      op_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
module tb_e_mdu;

  localparam int unsigned MultN = 5;
  localparam int unsigned DivN  = 10;

  localparam logic [3:0] OpNone  = 4'd0;
  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
  localparam logic [3:0] OpMfhi  = 4'd7;
  localparam logic [3:0] OpMflo  = 4'd8;

  logic        clk;
  logic        reset;
  logic        Req;
  logic        start;
  logic [3:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        busy;
  logic        busy_any;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mdu_out;

  int checks;
  int errors;

  e_mdu #(
    .MULT_CYCLES(MultN),
    .DIV_CYCLES (DivN)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .Req     (Req),
    .start   (start),
    .op      (op),
    .rs      (rs),
    .rt      (rt),
    .busy    (busy),
    .busy_any(busy_any),
    .hi      (hi),
    .lo      (lo),
    .mdu_out (mdu_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge, so they are stable at the next rising edge.
  task automatic cyc(input logic s, input logic [3:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic r);
    @(negedge clk);
    start = s;
    op    = o;
    rs    = a;
    rt    = b;
    Req   = r;
  endtask

  task automatic mt(input logic [3:0] o, input logic [31:0] v);
    cyc(1'b1, o, v, 32'd0, 1'b0);
    cyc(1'b0, OpNone, 32'd0, 32'd0, 1'b0);
  endtask

  // Called at the falling edge just after a start edge; counts busy cycles (bounded).
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  int n;

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    Req    = 1'b0;
    start  = 1'b0;
    op     = OpMfhi;
    rs     = 32'd0;
    rt     = 32'd0;

    vecs[0] = '{"mult_3x4",       OpMult,  32'd3,        32'd4,        32'h0,        32'd12,       MultN};
    vecs[1] = '{"mult_neg1x2",    OpMult,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, MultN};
    vecs[2] = '{"multu_maxx2",    OpMultu, 32'hFFFFFFFF, 32'd2,        32'h1,        32'hFFFFFFFE, MultN};
    vecs[3] = '{"multu_maxxmax",  OpMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1,        MultN};
    vecs[4] = '{"div_m7_2",       OpDiv,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DivN};
    vecs[5] = '{"div_7_m2",       OpDiv,   32'd7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD, DivN};
    vecs[6] = '{"divu_7_2",       OpDivu,  32'd7,        32'd2,        32'h1,        32'h3,        DivN};
    vecs[7] = '{"div_min_m1",     OpDiv,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, DivN};
    vecs[8] = '{"div_by_zero",    OpDiv,   32'd5,        32'd0,        32'hAA,       32'hBB,       DivN};
    vecs[9] = '{"divu_by_zero",   OpDivu,  32'd9,        32'd0,        32'hAA,       32'hBB,       DivN};

    // Reset held with the clock running.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_mfhi", mdu_out, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    op    = OpNone;

    // Table: preload HI/LO, read them back, run the op, check busy length and result.
    for (int i = 0; i < 10; i++) begin
      mt(OpMthi, 32'hAA);
      mt(OpMtlo, 32'hBB);
      op = OpMfhi;
      #1 chk({vecs[i].name, "_mfhi"}, mdu_out, 32'hAA);
      op = OpMflo;
      #1 chk({vecs[i].name, "_mflo"}, mdu_out, 32'hBB);
      cyc(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
      #1 chk({vecs[i].name, "_busy_any"}, {31'd0, busy_any}, 32'd1);
      // Scramble operands while running; the latched copies must be used.
      cyc(1'b0, OpNone, 32'hDEADBEEF, 32'h12345678, 1'b0);
      count_busy(n);
      chk({vecs[i].name, "_cycles"}, 32'(n), 32'(vecs[i].n));
      chk({vecs[i].name, "_hi"}, hi, vecs[i].hi);
      chk({vecs[i].name, "_lo"}, lo, vecs[i].lo);
    end

    // Req blocks a mult/div start and an MTLO write.
    mt(OpMthi, 32'h11);
    mt(OpMtlo, 32'h22);
    cyc(1'b1, OpMult, 32'd3, 32'd4, 1'b1);
    #1 chk("req_busy_any", {31'd0, busy_any}, 32'd0);
    cyc(1'b0, OpNone, 32'd0, 32'd0, 1'b0);
    chk("req_no_start", {31'd0, busy}, 32'd0);
    repeat (6) @(negedge clk);
    chk("req_hi_kept", hi, 32'h11);
    chk("req_lo_kept", lo, 32'h22);
    cyc(1'b1, OpMtlo, 32'd5, 32'd0, 1'b1);
    cyc(1'b0, OpNone, 32'd0, 32'd0, 1'b0);
    chk("req_mtlo_blocked", lo, 32'h22);

    // Req mid-run, MTHI and a new MULT while busy are ignored; MFHI returns old hi.
    cyc(1'b1, OpMultu, 32'd6, 32'd7, 1'b0);
    cyc(1'b0, OpNone, 32'd0, 32'd0, 1'b0);
    n = 1;
    cyc(1'b0, OpNone, 32'd0, 32'd0, 1'b1);
    n++;
    cyc(1'b1, OpMthi, 32'h99, 32'd0, 1'b0);
    n++;
    cyc(1'b1, OpMult, 32'd100, 32'd100, 1'b0);
    n++;
    op    = OpMfhi;
    start = 1'b0;
    #1 chk("busy_mfhi_old", mdu_out, 32'h11);
    cyc(1'b0, OpNone, 32'd0, 32'd0, 1'b0);
    n++;
    chk("busy_mid_run", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("busy_done", {31'd0, busy}, 32'd0);
    chk("mid_req_hi", hi, 32'd0);
    chk("mid_req_lo", lo, 32'd42);
    chk("mid_run_cycles", 32'(n), 32'(MultN));

    // Asynchronous reset in the middle of a DIV.
    mt(OpMthi, 32'h77);
    cyc(1'b1, OpDiv, 32'd100, 32'd3, 1'b0);
    cyc(1'b0, OpNone, 32'd0, 32'd0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    chk("arst_late_busy", {31'd0, busy}, 32'd0);
    chk("arst_late_hi", hi, 32'd0);
    chk("arst_late_lo", lo, 32'd0);

    // Unit is usable again after the abort.
    cyc(1'b1, OpDivu, 32'd100, 32'd3, 1'b0);
    cyc(1'b0, OpNone, 32'd0, 32'd0, 1'b0);
    count_busy(n);
    chk("post_rst_cycles", 32'(n), 32'(DivN));
    chk("post_rst_hi", hi, 32'd1);
    chk("post_rst_lo", lo, 32'd33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
